// File: rtl/avl_wait_bridge.sv
// Avalon-MM pass-through that holds each master request for a fixed or LFSR-driven
// number of extra wait cycles, checks master-side protocol and counts transfers.
module avl_wait_bridge #(
   parameter int unsigned RANDOM      = 1,
   parameter int unsigned FIXED_STALL = 2,
   parameter int unsigned STALL_BITS  = 3,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] m_address,
   input  logic        m_read,
   input  logic        m_write,
   input  logic [3:0]  m_byteenable,
   input  logic [31:0] m_writedata,
   output logic [31:0] m_readdata,
   output logic        m_waitrequest,
   output logic [31:0] s_address,
   output logic        s_read,
   output logic        s_write,
   output logic [3:0]  s_byteenable,
   output logic [31:0] s_writedata,
   input  logic [31:0] s_readdata,
   input  logic        s_waitrequest,
   output logic        protocol_error,
   output logic [31:0] xfer_count
);

   typedef enum logic [1:0] {IDLE, STALL, FWD} state_t;

   state_t      state_q, state_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [31:0] addr_q, addr_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wd_q, wd_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        perr_q, perr_d;
   logic [31:0] xcnt_q, xcnt_d;

   logic        m_req;
   logic [3:0]  stall_init;
   logic        req_mismatch;

   assign m_req = m_read | m_write;

   generate
      if (RANDOM != 0) begin : g_rand
         assign stall_init = 4'(lfsr_q[STALL_BITS-1:0]);
      end else begin : g_fixed
         assign stall_init = 4'(FIXED_STALL);
      end
   endgenerate

   assign req_mismatch = (m_address != addr_q) || (m_read != rd_q) || (m_write != wr_q) ||
                         (m_byteenable != be_q) || (m_writedata != wd_q) || !m_req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         lfsr_q  <= LFSR_SEED;
         addr_q  <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         be_q    <= '0;
         wd_q    <= '0;
         cnt_q   <= '0;
         perr_q  <= 1'b0;
         xcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         be_q    <= be_d;
         wd_q    <= wd_d;
         cnt_q   <= cnt_d;
         perr_q  <= perr_d;
         xcnt_q  <= xcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      addr_d  = addr_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      be_d    = be_q;
      wd_d    = wd_q;
      cnt_d   = cnt_q;
      perr_d  = perr_q;
      xcnt_d  = xcnt_q;

      if (m_read && m_write)
         perr_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (m_req) begin
               addr_d  = m_address;
               rd_d    = m_read;
               wr_d    = m_write;
               be_d    = m_byteenable;
               wd_d    = m_writedata;
               cnt_d   = stall_init;
               state_d = (stall_init != '0) ? STALL : FWD;
            end
         end
         STALL: begin
            if (req_mismatch)
               perr_d = 1'b1;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1)
               state_d = FWD;
         end
         FWD: begin
            if (req_mismatch)
               perr_d = 1'b1;
            if (!s_waitrequest) begin
               xcnt_d  = xcnt_q + 32'd1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Captured request is forwarded even if the master has since changed or dropped it.
   always_comb begin
      m_waitrequest = 1'b1;
      m_readdata    = '0;
      s_read        = 1'b0;
      s_write       = 1'b0;
      if (!rst) begin
         case (state_q)
            IDLE:    m_waitrequest = m_req;
            STALL:   m_waitrequest = 1'b1;
            FWD: begin
               m_waitrequest = s_waitrequest;
               s_read        = rd_q;
               s_write       = wr_q;
               if (!s_waitrequest)
                  m_readdata = s_readdata;
            end
            default: m_waitrequest = 1'b1;
         endcase
      end
   end

   assign s_address      = addr_q;
   assign s_byteenable   = be_q;
   assign s_writedata    = wd_q;
   assign protocol_error = perr_q;
   assign xfer_count     = xcnt_q;

endmodule

// File: tb/tb_avl_wait_bridge.sv
// Directed bench for avl_wait_bridge: three parameterisations share one master driver
// and one memory-backed slave model; sel picks the instance under test.
module tb_avl_wait_bridge;

   localparam logic [31:0] MEM_KEY = 32'h33C20004;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  sel = 2'd0;
   logic [31:0] m_address = '0;
   logic        m_read = 1'b0;
   logic        m_write = 1'b0;
   logic [3:0]  m_be = '0;
   logic [31:0] m_wd = '0;

   logic        mr [3];
   logic        mw [3];
   logic [31:0] m_rdata_o [3];
   logic        m_wait_o [3];
   logic [31:0] s_addr_o [3];
   logic        s_rd_o [3];
   logic        s_wr_o [3];
   logic [3:0]  s_be_o [3];
   logic [31:0] s_wd_o [3];
   logic        perr_o [3];
   logic [31:0] xcnt_o [3];

   logic [31:0] s_rdata;
   logic        slv_wait;
   int          slv_wait_cycles = 0;
   int          fwd_cnt = 0;
   logic [31:0] mem [256];
   logic        valid [256];

   int n_checks = 0;
   int n_fails  = 0;

   // observations captured by do_xfer
   int          obs_first_s;
   logic [31:0] obs_addr;
   logic [3:0]  obs_be;
   logic [31:0] obs_wd;

   always #5 clk = ~clk;

   assign mr[0] = m_read  && (sel == 2'd0);
   assign mw[0] = m_write && (sel == 2'd0);
   assign mr[1] = m_read  && (sel == 2'd1);
   assign mw[1] = m_write && (sel == 2'd1);
   assign mr[2] = m_read  && (sel == 2'd2);
   assign mw[2] = m_write && (sel == 2'd2);

   logic [31:0] cur_m_rdata, cur_s_addr, cur_s_wd, cur_xcnt;
   logic        cur_m_wait, cur_s_rd, cur_s_wr, cur_perr;
   logic [3:0]  cur_s_be;
   assign cur_m_rdata = m_rdata_o[sel];
   assign cur_m_wait  = m_wait_o[sel];
   assign cur_s_addr  = s_addr_o[sel];
   assign cur_s_rd    = s_rd_o[sel];
   assign cur_s_wr    = s_wr_o[sel];
   assign cur_s_be    = s_be_o[sel];
   assign cur_s_wd    = s_wd_o[sel];
   assign cur_perr    = perr_o[sel];
   assign cur_xcnt    = xcnt_o[sel];

   avl_wait_bridge #(.RANDOM(0), .FIXED_STALL(2), .STALL_BITS(3), .LFSR_SEED(16'hACE1)) u_fix2 (
      .clk(clk), .rst(rst), .m_address(m_address), .m_read(mr[0]), .m_write(mw[0]),
      .m_byteenable(m_be), .m_writedata(m_wd), .m_readdata(m_rdata_o[0]), .m_waitrequest(m_wait_o[0]),
      .s_address(s_addr_o[0]), .s_read(s_rd_o[0]), .s_write(s_wr_o[0]), .s_byteenable(s_be_o[0]),
      .s_writedata(s_wd_o[0]), .s_readdata(s_rdata), .s_waitrequest(slv_wait),
      .protocol_error(perr_o[0]), .xfer_count(xcnt_o[0]));

   avl_wait_bridge #(.RANDOM(0), .FIXED_STALL(0), .STALL_BITS(3), .LFSR_SEED(16'hACE1)) u_fix0 (
      .clk(clk), .rst(rst), .m_address(m_address), .m_read(mr[1]), .m_write(mw[1]),
      .m_byteenable(m_be), .m_writedata(m_wd), .m_readdata(m_rdata_o[1]), .m_waitrequest(m_wait_o[1]),
      .s_address(s_addr_o[1]), .s_read(s_rd_o[1]), .s_write(s_wr_o[1]), .s_byteenable(s_be_o[1]),
      .s_writedata(s_wd_o[1]), .s_readdata(s_rdata), .s_waitrequest(slv_wait),
      .protocol_error(perr_o[1]), .xfer_count(xcnt_o[1]));

   avl_wait_bridge #(.RANDOM(1), .FIXED_STALL(2), .STALL_BITS(3), .LFSR_SEED(16'hACE1)) u_rand (
      .clk(clk), .rst(rst), .m_address(m_address), .m_read(mr[2]), .m_write(mw[2]),
      .m_byteenable(m_be), .m_writedata(m_wd), .m_readdata(m_rdata_o[2]), .m_waitrequest(m_wait_o[2]),
      .s_address(s_addr_o[2]), .s_read(s_rd_o[2]), .s_write(s_wr_o[2]), .s_byteenable(s_be_o[2]),
      .s_writedata(s_wd_o[2]), .s_readdata(s_rdata), .s_waitrequest(slv_wait),
      .protocol_error(perr_o[2]), .xfer_count(xcnt_o[2]));

   // Slave: unwritten words read as address ^ MEM_KEY; stalls slv_wait_cycles per access.
   assign slv_wait = (cur_s_rd || cur_s_wr) && (fwd_cnt < slv_wait_cycles);
   assign s_rdata  = cur_s_rd ? (valid[cur_s_addr[9:2]] ? mem[cur_s_addr[9:2]] : (cur_s_addr ^ MEM_KEY)) : '0;

   always @(posedge clk) begin
      logic [31:0] w;
      if (rst) begin
         for (int i = 0; i < 256; i++) valid[i] <= 1'b0;
         fwd_cnt <= 0;
      end else if (cur_s_rd || cur_s_wr) begin
         if (slv_wait) fwd_cnt <= fwd_cnt + 1;
         else begin
            fwd_cnt <= 0;
            if (cur_s_wr) begin
               w = valid[cur_s_addr[9:2]] ? mem[cur_s_addr[9:2]] : (cur_s_addr ^ MEM_KEY);
               for (int b = 0; b < 4; b++)
                  if (cur_s_be[b]) w[8*b +: 8] = cur_s_wd[8*b +: 8];
               mem[cur_s_addr[9:2]]   <= w;
               valid[cur_s_addr[9:2]] <= 1'b1;
            end
         end
      end
   end

   task automatic apply_reset;
      rst = 1'b1; m_read = 1'b0; m_write = 1'b0; slv_wait_cycles = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Called #1 after a rising edge; returns #1 after the completing edge with the request dropped.
   task automatic do_xfer(input bit wr, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                          output logic [31:0] rd, output int wcyc, output int scyc, output bit done);
      m_address = a; m_read = !wr; m_write = wr; m_be = be; m_wd = wd;
      wcyc = 0; scyc = 0; done = 1'b0; rd = '0; obs_first_s = -1;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (cur_s_rd || cur_s_wr) begin
            if (obs_first_s < 0) begin
               obs_first_s = i; obs_addr = cur_s_addr; obs_be = cur_s_be; obs_wd = cur_s_wd;
            end
            scyc++;
         end
         if (cur_m_wait) wcyc++;
         else begin done = 1'b1; rd = cur_m_rdata; end
         @(posedge clk); #1;
      end
      m_read = 1'b0; m_write = 1'b0;
   endtask

   task automatic test_reset;
      sel = 2'd0; rst = 1'b1; m_read = 1'b1; m_address = 32'h10;
      #1;
      n_checks++; if (cur_m_wait !== 1'b1) begin n_fails++; $display("FAIL reset_wait: got %b expected 1", cur_m_wait); end
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (s_rd_o[k] !== 1'b0 || s_wr_o[k] !== 1'b0 || perr_o[k] !== 1'b0 || xcnt_o[k] !== 32'd0) begin
            n_fails++;
            $display("FAIL reset_regs[%0d]: got rd=%b wr=%b perr=%b cnt=%0d expected 0 0 0 0",
                     k, s_rd_o[k], s_wr_o[k], perr_o[k], xcnt_o[k]);
         end
      end
      m_read = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      n_checks++; if (cur_m_wait !== 1'b0) begin n_fails++; $display("FAIL idle_wait: got %b expected 0", cur_m_wait); end
      n_checks++; if (cur_m_rdata !== 32'd0) begin n_fails++; $display("FAIL idle_rdata: got %h expected 0", cur_m_rdata); end
      @(posedge clk); #1;
   endtask

   task automatic test_fixed_read;
      logic [31:0] rd; int wc, sc; bit ok;
      sel = 2'd0; apply_reset();
      do_xfer(1'b0, 32'hBFC00000, 4'hF, 32'h0, rd, wc, sc, ok);
      n_checks++; if (ok !== 1'b1) begin n_fails++; $display("FAIL t1_done: got %b expected 1", ok); end
      n_checks++; if (wc != 3) begin n_fails++; $display("FAIL t1_wait_cycles: got %0d expected 3", wc); end
      n_checks++; if (sc != 1) begin n_fails++; $display("FAIL t1_sread_cycles: got %0d expected 1", sc); end
      n_checks++; if (rd !== 32'h8C020004) begin n_fails++; $display("FAIL t1_rdata: got %h expected 8c020004", rd); end
      n_checks++; if (cur_xcnt !== 32'd1) begin n_fails++; $display("FAIL t1_xcnt: got %0d expected 1", cur_xcnt); end
   endtask

   task automatic test_zero_stall_write;
      logic [31:0] rd; int wc, sc; bit ok;
      sel = 2'd1; apply_reset();
      slv_wait_cycles = 3;
      do_xfer(1'b1, 32'h00001000, 4'b0011, 32'hDEADBEEF, rd, wc, sc, ok);
      n_checks++; if (ok !== 1'b1) begin n_fails++; $display("FAIL t2_done: got %b expected 1", ok); end
      n_checks++; if (wc != 4) begin n_fails++; $display("FAIL t2_wait_cycles: got %0d expected 4", wc); end
      n_checks++; if (obs_first_s != 1) begin n_fails++; $display("FAIL t2_swrite_cycle: got %0d expected 1", obs_first_s); end
      n_checks++;
      if (obs_addr !== 32'h1000 || obs_be !== 4'b0011 || obs_wd !== 32'hDEADBEEF) begin
         n_fails++;
         $display("FAIL t2_fwd_fields: got %h %b %h expected 00001000 0011 deadbeef", obs_addr, obs_be, obs_wd);
      end
      n_checks++; if (cur_xcnt !== 32'd1) begin n_fails++; $display("FAIL t2_xcnt: got %0d expected 1", cur_xcnt); end
      slv_wait_cycles = 0;
      do_xfer(1'b0, 32'h00001000, 4'hF, 32'h0, rd, wc, sc, ok);
      n_checks++; if (wc != 1) begin n_fails++; $display("FAIL t2_rb_wait: got %0d expected 1", wc); end
      n_checks++; if (rd !== 32'h33C2BEEF) begin n_fails++; $display("FAIL t2_readback: got %h expected 33c2beef", rd); end
      n_checks++; if (cur_perr !== 1'b0) begin n_fails++; $display("FAIL t2_perr: got %b expected 0", cur_perr); end
   endtask

   task automatic test_random;
      logic [31:0] ref_mem [logic [31:0]];
      logic [31:0] rd, a, wd, exp_d, w;
      logic [3:0]  be;
      logic [15:0] seen;
      int wc, sc, timeouts;
      bit ok, wr;
      sel = 2'd2; apply_reset();
      seen = '0; timeouts = 0;
      for (int t = 0; t < 100; t++) begin
         a  = {22'd0, 4'($urandom_range(0, 15)), 6'd0};
         wr = 1'($urandom_range(0, 1));
         be = wr ? 4'($urandom_range(1, 15)) : 4'hF;
         wd = $urandom;
         do_xfer(wr, a, be, wd, rd, wc, sc, ok);
         if (!ok) timeouts++;
         else if (wc >= 1 && wc <= 16) seen[wc-1] = 1'b1;
         exp_d = ref_mem.exists(a) ? ref_mem[a] : (a ^ MEM_KEY);
         if (wr) begin
            w = exp_d;
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
            ref_mem[a] = w;
         end else begin
            n_checks++;
            if (rd !== exp_d) begin n_fails++; $display("FAIL t3_read[%0d]: addr %h got %h expected %h", t, a, rd, exp_d); end
         end
      end
      n_checks++; if (timeouts != 0) begin n_fails++; $display("FAIL t3_timeouts: got %0d expected 0", timeouts); end
      n_checks++; if (cur_perr !== 1'b0) begin n_fails++; $display("FAIL t3_perr: got %b expected 0", cur_perr); end
      n_checks++; if (cur_xcnt !== 32'd100) begin n_fails++; $display("FAIL t3_xcnt: got %0d expected 100", cur_xcnt); end
      n_checks++; if ($countones(seen) < 4) begin n_fails++; $display("FAIL t3_stall_variety: got %0d expected >=4", $countones(seen)); end
   endtask

   task automatic test_addr_change;
      bit ok;
      sel = 2'd0; apply_reset();
      m_address = 32'h40; m_read = 1'b1; m_be = 4'hF; m_wd = '0;
      @(posedge clk); #1;
      m_address = 32'h80;
      @(negedge clk);
      n_checks++; if (cur_perr !== 1'b0) begin n_fails++; $display("FAIL t4_perr_before: got %b expected 0", cur_perr); end
      @(posedge clk); #1;
      n_checks++; if (cur_perr !== 1'b1) begin n_fails++; $display("FAIL t4_perr_rise: got %b expected 1", cur_perr); end
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (!cur_m_wait) begin
            ok = 1'b1;
            n_checks++;
            if (cur_s_addr !== 32'h40 || cur_s_rd !== 1'b1) begin
               n_fails++; $display("FAIL t4_fwd_addr: got %h rd=%b expected 00000040 rd=1", cur_s_addr, cur_s_rd);
            end
         end
         @(posedge clk); #1;
      end
      m_read = 1'b0;
      n_checks++; if (ok !== 1'b1) begin n_fails++; $display("FAIL t4_done: got %b expected 1", ok); end
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (cur_perr !== 1'b1) begin n_fails++; $display("FAIL t4_perr_sticky: got %b expected 1", cur_perr); end
      n_checks++; if (cur_xcnt !== 32'd1) begin n_fails++; $display("FAIL t4_xcnt: got %0d expected 1", cur_xcnt); end
   endtask

   task automatic test_read_write_both;
      sel = 2'd1; apply_reset();
      m_address = 32'h20; m_read = 1'b1; m_write = 1'b1; m_be = 4'hF; m_wd = 32'h5;
      @(negedge clk);
      n_checks++; if (cur_perr !== 1'b0) begin n_fails++; $display("FAIL t5_perr_before: got %b expected 0", cur_perr); end
      @(posedge clk); #1;
      n_checks++; if (cur_perr !== 1'b1) begin n_fails++; $display("FAIL t5_perr: got %b expected 1", cur_perr); end
      m_read = 1'b0; m_write = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid;
      logic [31:0] rd; int wc, sc; bit ok, found;
      sel = 2'd0; apply_reset();
      do_xfer(1'b0, 32'h100, 4'hF, 32'h0, rd, wc, sc, ok);
      n_checks++; if (cur_xcnt !== 32'd1) begin n_fails++; $display("FAIL t6_xcnt_pre: got %0d expected 1", cur_xcnt); end
      slv_wait_cycles = 10;
      m_address = 32'h104; m_read = 1'b1; m_be = 4'hF; m_wd = '0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (cur_s_rd) found = 1'b1;
         else begin @(posedge clk); #1; end
      end
      n_checks++; if (found !== 1'b1 || cur_m_wait !== 1'b1) begin n_fails++; $display("FAIL t6_fwd: got found=%b wait=%b expected 1 1", found, cur_m_wait); end
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if (cur_s_rd !== 1'b0 || cur_m_wait !== 1'b1 || cur_xcnt !== 32'd0) begin
         n_fails++; $display("FAIL t6_async_rst: got rd=%b wait=%b cnt=%0d expected 0 1 0", cur_s_rd, cur_m_wait, cur_xcnt);
      end
      m_read = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; slv_wait_cycles = 0;
      do_xfer(1'b0, 32'h108, 4'hF, 32'h0, rd, wc, sc, ok);
      n_checks++; if (ok !== 1'b1 || wc != 3) begin n_fails++; $display("FAIL t6_after_wait: got done=%b wait=%0d expected 1 3", ok, wc); end
      n_checks++; if (rd !== (32'h108 ^ MEM_KEY)) begin n_fails++; $display("FAIL t6_after_rdata: got %h expected %h", rd, 32'h108 ^ MEM_KEY); end
      n_checks++; if (cur_xcnt !== 32'd1) begin n_fails++; $display("FAIL t6_xcnt_post: got %0d expected 1", cur_xcnt); end
   endtask

   initial begin
      test_reset();
      test_fixed_read();
      test_zero_stall_write();
      test_random();
      test_addr_change();
      test_read_write_both();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
